video_timing_gen: RTL and testbench

- Consumer-side counterpart of the pixel clock divider. Runs in the clk_pix domain and turns the divider's synchronised lock flag into display raster timing: hsync, vsync, data-enable, pixel coordinates and frame/line strobes.
- Sits between the clock divider and the TMDS/HDMI encoder.
- Holds the raster idle until lock has been continuously stable for a programmable number of cycles.
- Drops back to idle immediately if lock is lost.

---
 rtl/video_timing_gen.sv | 190 +++++++++++++++++++
 tb/tb_video_timing_gen.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator: waits for a stable pixel-clock lock, then emits hsync/vsync/de, coordinates and strobes.
// Optional colour-bar test pattern on rgb when VTG_TEST_PATTERN_EN is defined; otherwise rgb is tied to zero.
module video_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit H_POL     = 1'b0,
  parameter bit V_POL     = 1'b0,
  parameter int LOCK_WAIT = 16,
  parameter int CW        = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_locked,
  output logic          running,
  output logic [CW-1:0] sx,
  output logic [CW-1:0] sy,
  output logic          de,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start,
  output logic [23:0]   rgb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEGIN = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEGIN = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  localparam int WW = ($clog2(LOCK_WAIT + 1) < 1) ? 1 : $clog2(LOCK_WAIT + 1);
  localparam logic [WW-1:0] WAIT_DONE = WW'(LOCK_WAIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [CW-1:0] sx_q, sx_d;
  logic [CW-1:0] sy_q, sy_d;
  logic          run_q, run_d;
  logic          de_q, de_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic [23:0]   rgb_d, rgb_q;

`ifdef VTG_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  logic [CW-1:0] bar_quot;
  logic [2:0]    bar_idx;
`endif

  // Next-state and next-position logic; outputs below are derived from the
  // position that will be registered, so they line up with sx/sy.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    sx_d    = '0;
    sy_d    = '0;
    run_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        wait_d = '0;
        if (pix_locked) begin
          state_d = ST_WAIT;
          wait_d  = WW'(1);
        end
      end
      ST_WAIT: begin
        if (!pix_locked) begin
          state_d = ST_IDLE;
          wait_d  = '0;
        end else if (wait_q == WAIT_DONE) begin
          state_d = ST_RUN;
          wait_d  = '0;
          run_d   = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!pix_locked) begin
          state_d = ST_IDLE;
        end else begin
          run_d = 1'b1;
          if (sx_q == H_LAST) begin
            sx_d = '0;
            sy_d = (sy_q == V_LAST) ? '0 : sy_q + 1'b1;
          end else begin
            sx_d = sx_q + 1'b1;
            sy_d = sy_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        wait_d  = '0;
      end
    endcase
  end

  always_comb begin
    de_d          = run_d && (sx_d < H_ACT) && (sy_d < V_ACT);
    hsync_d       = (run_d && (sx_d >= HS_BEGIN) && (sx_d < HS_END)) ? H_POL : ~H_POL;
    vsync_d       = (run_d && (sy_d >= VS_BEGIN) && (sy_d < VS_END)) ? V_POL : ~V_POL;
    line_start_d  = run_d && (sx_d == '0);
    frame_start_d = run_d && (sx_d == '0) && (sy_d == '0);
  end

`ifdef VTG_TEST_PATTERN_EN
  // Bars past the eighth (when H_ACTIVE is not a multiple of 8) stay black.
  always_comb begin
    bar_quot = sx_d / CW'(BAR_W);
    bar_idx  = (bar_quot > CW'(7)) ? 3'd7 : bar_quot[2:0];
    rgb_d    = 24'h000000;
    if (de_d) begin
      unique case (bar_idx)
        3'd0: rgb_d = 24'hFFFFFF;
        3'd1: rgb_d = 24'hFFFF00;
        3'd2: rgb_d = 24'h00FFFF;
        3'd3: rgb_d = 24'h00FF00;
        3'd4: rgb_d = 24'hFF00FF;
        3'd5: rgb_d = 24'hFF0000;
        3'd6: rgb_d = 24'h0000FF;
        default: rgb_d = 24'h000000;
      endcase
    end
  end
`else
  always_comb begin
    rgb_d = 24'h000000;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      wait_q        <= '0;
      sx_q          <= '0;
      sy_q          <= '0;
      run_q         <= 1'b0;
      de_q          <= 1'b0;
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      rgb_q         <= 24'h000000;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      sx_q          <= sx_d;
      sy_q          <= sy_d;
      run_q         <= run_d;
      de_q          <= de_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      rgb_q         <= rgb_d;
    end
  end

  assign running     = run_q;
  assign sx          = sx_q;
  assign sy          = sy_q;
  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign rgb         = rgb_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a reduced raster (32x20) with a lock-streak / frame-position reference model.
module tb_video_timing_gen;

  localparam int HA = 16, HFP = 4, HSW = 6, HBP = 6;
  localparam int VA = 12, VFP = 2, VSW = 3, VBP = 3;
  localparam bit HPOL = 1'b0, VPOL = 1'b1;
  localparam int LW = 16, CW = 12;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pix_locked = 1'b0;
  logic          running, de, hsync, vsync, line_start, frame_start;
  logic [CW-1:0] sx, sy;
  logic [23:0]   rgb;

  int checks = 0;
  int failures = 0;

  // Model: length of the current unbroken lock streak and position within the frame.
  bit m_run = 1'b0;
  int m_streak = 0;
  int m_pos = 0;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .H_POL(HPOL), .V_POL(VPOL), .LOCK_WAIT(LW), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .pix_locked(pix_locked), .running(running),
    .sx(sx), .sy(sy), .de(de), .hsync(hsync), .vsync(vsync),
    .line_start(line_start), .frame_start(frame_start), .rgb(rgb)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] bar_colour(input int x);
    int idx;
    idx = x / (HA / 8);
    if (idx > 7) idx = 7;
    case (idx)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic check_all();
    int ex, ey;
    bit e_de;
    logic [23:0] e_rgb;
    ex = m_run ? (m_pos % HT) : 0;
    ey = m_run ? (m_pos / HT) : 0;
    e_de = m_run && ex < HA && ey < VA;
`ifdef VTG_TEST_PATTERN_EN
    e_rgb = e_de ? bar_colour(ex) : 24'h000000;
`else
    e_rgb = 24'h000000;
`endif
    chk("running", 32'(running), 32'(m_run));
    chk("sx", 32'(sx), ex);
    chk("sy", 32'(sy), ey);
    chk("de", 32'(de), 32'(e_de));
    chk("hsync", 32'(hsync), 32'((m_run && ex >= HA + HFP && ex < HA + HFP + HSW) ? HPOL : !HPOL));
    chk("vsync", 32'(vsync), 32'((m_run && ey >= VA + VFP && ey < VA + VFP + VSW) ? VPOL : !VPOL));
    chk("line_start", 32'(line_start), 32'(m_run && ex == 0));
    chk("frame_start", 32'(frame_start), 32'(m_run && ex == 0 && ey == 0));
    chk("rgb", 32'(rgb), 32'(e_rgb));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst || !pix_locked) begin
      m_run = 1'b0;
      m_streak = 0;
      m_pos = 0;
    end else if (m_run) begin
      m_pos = (m_pos + 1) % (HT * VT);
    end else begin
      m_streak++;
      if (m_streak == LW + 1) begin
        m_run = 1'b1;
        m_pos = 0;
      end
    end
    #1;
    check_all();
  endtask

  // Counts edges from the current inputs until running rises; the edge that
  // first samples lock counts as 1, so the raster starts on edge LW+1.
  task automatic wait_run(input string tag);
    int n;
    n = 0;
    while (running !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_start_edges"}, n, LW + 1);
    chk({tag, "_first_sx"}, 32'(sx), 0);
    chk({tag, "_first_sy"}, 32'(sy), 0);
    chk({tag, "_first_frame_start"}, 32'(frame_start), 1);
    chk({tag, "_first_de"}, 32'(de), 1);
  endtask

  task automatic run_to(input string tag, input int x, input int y);
    int n;
    n = 0;
    while (!(m_run && m_pos == y * HT + x) && n < 2 * HT * VT) begin
      tick();
      n++;
    end
    chk({tag, "_reached"}, 32'(m_run && m_pos == y * HT + x), 1);
  endtask

  initial begin
    int c_fs, c_ls, c_de, c_hs, c_vs;

    // Reset held for 4 cycles.
    rst = 1'b1;
    pix_locked = 1'b0;
    repeat (4) tick();
    chk("rst_hsync", 32'(hsync), 32'(!HPOL));
    chk("rst_vsync", 32'(vsync), 32'(!VPOL));

    // Startup.
    rst = 1'b0;
    pix_locked = 1'b1;
    wait_run("startup");

    // Two full frames: aggregate timing counts.
    c_fs = 0; c_ls = 0; c_de = 0; c_hs = 0; c_vs = 0;
    for (int i = 0; i < 2 * HT * VT; i++) begin
      tick();
      c_fs += int'(frame_start);
      c_ls += int'(line_start);
      c_de += int'(de);
      c_hs += int'(hsync == HPOL);
      c_vs += int'(vsync == VPOL);
    end
    chk("frame_start_count", c_fs, 2);
    chk("line_start_count", c_ls, 2 * VT);
    chk("de_count", c_de, 2 * HA * VA);
    chk("hsync_active_count", c_hs, 2 * HSW * VT);
    chk("vsync_active_count", c_vs, 2 * VSW * HT);

    // Lock drop in RUN mid-frame.
    run_to("mid", 10, 5);
    pix_locked = 1'b0;
    tick();
    chk("drop_running", 32'(running), 0);
    chk("drop_sx", 32'(sx), 0);
    chk("drop_hsync", 32'(hsync), 32'(!HPOL));
    chk("drop_vsync", 32'(vsync), 32'(!VPOL));

    // One-cycle glitch at wait count 10 restarts the wait.
    pix_locked = 1'b1;
    repeat (10) tick();
    pix_locked = 1'b0;
    tick();
    pix_locked = 1'b1;
    wait_run("glitch");

    // Lock falls exactly when the wait would complete.
    pix_locked = 1'b0;
    tick();
    pix_locked = 1'b1;
    repeat (LW) tick();
    pix_locked = 1'b0;
    tick();
    chk("late_drop_running", 32'(running), 0);
    pix_locked = 1'b1;
    wait_run("late_drop");

    // Reset mid-frame inside both sync regions, lock held high.
    run_to("sync", HA + HFP + HSW - 1, VA + VFP);
    rst = 1'b1;
    tick();
    chk("midrst_running", 32'(running), 0);
    chk("midrst_sy", 32'(sy), 0);
    chk("midrst_hsync", 32'(hsync), 32'(!HPOL));
    chk("midrst_vsync", 32'(vsync), 32'(!VPOL));
    rst = 1'b0;
    wait_run("after_rst");

    // Randomised lock dropouts and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      pix_locked = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
